// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths: register/operand sizes, ALU op codes, control bundle, ID/EX FSM states.
// No logic; imported by the ID/EX stage and its hazard detector.
package pipeline_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_W    = 5;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_e;

    // Control bits of a non-instruction must never cause side effects downstream.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic vld);
        return vld ? c : '0;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: purely combinational, zero latency.
// No backpressure of its own; the caller turns luh_o into a stall/bubble.
module load_use_detect #(
    parameter int REG_W    = pipeline_pkg::REG_W,
    parameter int ZERO_REG = pipeline_pkg::ZERO_REG
) (
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    output logic             luh_o
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
    assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);
    assign luh_o  = ex_valid_i && ex_mem_read_i && (ex_rd_i != ZERO_IDX)
                 && id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory-wait freeze.
// Latency 1 cycle; mem_busy holds everything, a load-use hazard inserts one bubble and raises stall.
module id_ex_stage #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int REG_W    = pipeline_pkg::REG_W,
    parameter int ZERO_REG = pipeline_pkg::ZERO_REG,
    parameter int CNT_W    = pipeline_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  stall_count,
    output logic              frozen
);

    import pipeline_pkg::*;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [REG_W-1:0]    rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [3:0]          alu_op_q, alu_op_d;
    ctrl_t               ctrl_q, ctrl_d, id_ctrl;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                luh;

    load_use_detect #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_luh (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .luh_o         (luh)
    );

    // Not gated by ex_flush: the upstream redirect already overrides the hold.
    assign stall = luh || mem_busy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (mem_busy)  state_d = FREEZE;
            FREEZE: if (!mem_busy) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign id_ctrl = '{alu_src: id_alu_src, reg_write: id_reg_write,
                       mem_read: id_mem_read, mem_write: id_mem_write};

    // Action keys off the live mem_busy input, so the freeze takes effect on its first cycle.
    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        alu_op_d  = alu_op_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        if (!mem_busy) begin
            if (ex_flush || luh) begin
                valid_d   = 1'b0;
                rs_d      = '0;
                rt_d      = '0;
                rd_d      = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                alu_op_d  = '0;
                ctrl_d    = '0;
                if (!ex_flush && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d   = id_valid;
                rs_d      = id_rs;
                rt_d      = id_rt;
                rd_d      = id_rd;
                rs_data_d = id_rs_data;
                rt_data_d = id_rt_data;
                imm_d     = id_imm;
                alu_op_d  = id_alu_op;
                ctrl_d    = gate_ctrl(id_ctrl, id_valid);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_op_q  <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            alu_op_q  <= alu_op_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign stall_count  = cnt_q;
    assign frozen       = (state_q == FREEZE);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage, instantiated with a 4-bit stall counter.
module tb_id_ex_stage;
    import pipeline_pkg::*;

    localparam int TB_CNT_W = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic       id_uses_rs, id_uses_rt, ex_flush, mem_busy;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [7:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0] id_alu_op;
    logic       stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, frozen;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic [7:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [3:0] ex_alu_op;
    logic [TB_CNT_W-1:0] stall_count;

    id_ex_stage #(
        .DATA_W(8), .REG_W(5), .ZERO_REG(31), .CNT_W(TB_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_flush(ex_flush), .mem_busy(mem_busy), .stall(stall),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_count(stall_count), .frozen(frozen)
    );

    typedef struct packed {
        logic       vld;
        logic [4:0] rs, rt, rd;
        logic [7:0] rsd, rtd, imm;
        logic [3:0] op;
        logic       src, rw, mr, mw, urs, urt;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       fl, busy;
        logic       e_stall;
        instr_t     e_ex;
        logic [3:0] e_cnt;
        logic       e_frz;
    } tv_t;

    tv_t tbl[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    instr_t A, LD5, U5, U5N, U5N_E, LD31, U31, LD6, N6, INV, INV_E, RT6, BUB;

    function automatic instr_t mk(input logic vld, input logic [4:0] rs, rt, rd,
                                  input logic [7:0] rsd, rtd, imm, input logic [3:0] op,
                                  input logic src, rw, mr, mw, urs, urt);
        instr_t i;
        i.vld = vld; i.rs = rs; i.rt = rt; i.rd = rd;
        i.rsd = rsd; i.rtd = rtd; i.imm = imm; i.op = op;
        i.src = src; i.rw = rw; i.mr = mr; i.mw = mw; i.urs = urs; i.urt = urt;
        return i;
    endfunction

    task automatic add(input instr_t ins, input logic fl, busy, e_stall,
                       input instr_t e_ex, input logic [3:0] e_cnt, input logic e_frz);
        tv_t t;
        t.ins = ins; t.fl = fl; t.busy = busy; t.e_stall = e_stall;
        t.e_ex = e_ex; t.e_cnt = e_cnt; t.e_frz = e_frz;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge.
    task automatic apply(input instr_t i, input logic fl, busy, r);
        @(negedge clk);
        rst = r; ex_flush = fl; mem_busy = busy;
        id_valid = i.vld; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm; id_alu_op = i.op;
        id_alu_src = i.src; id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
        id_uses_rs = i.urs; id_uses_rt = i.urt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string p, input instr_t e);
        chk({p, " ex_valid"},     32'(ex_valid),     32'(e.vld));
        chk({p, " ex_rs"},        32'(ex_rs),        32'(e.rs));
        chk({p, " ex_rt"},        32'(ex_rt),        32'(e.rt));
        chk({p, " ex_rd"},        32'(ex_rd),        32'(e.rd));
        chk({p, " ex_rs_data"},   32'(ex_rs_data),   32'(e.rsd));
        chk({p, " ex_rt_data"},   32'(ex_rt_data),   32'(e.rtd));
        chk({p, " ex_imm"},       32'(ex_imm),       32'(e.imm));
        chk({p, " ex_alu_op"},    32'(ex_alu_op),    32'(e.op));
        chk({p, " ex_alu_src"},   32'(ex_alu_src),   32'(e.src));
        chk({p, " ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
        chk({p, " ex_mem_read"},  32'(ex_mem_read),  32'(e.mr));
        chk({p, " ex_mem_write"}, 32'(ex_mem_write), 32'(e.mw));
    endtask

    initial begin
        BUB   = '0;
        A     = mk(1, 2, 3, 4, 8'h12, 8'h34, 8'h56, ALU_ADD, 0, 1, 0, 0, 1, 1);
        LD5   = mk(1, 1, 7, 5, 8'h20, 8'h00, 8'h04, ALU_ADD, 1, 1, 1, 0, 1, 0);
        U5    = mk(1, 5, 8, 9, 8'h11, 8'h22, 8'h00, ALU_SUB, 0, 1, 0, 0, 1, 1);
        U5N   = mk(0, 5, 8, 9, 8'h11, 8'h22, 8'h00, ALU_SUB, 0, 1, 0, 0, 1, 1);
        U5N_E = mk(0, 5, 8, 9, 8'h11, 8'h22, 8'h00, ALU_SUB, 0, 0, 0, 0, 1, 1);
        LD31  = mk(1, 2, 0, 31, 8'h40, 8'h00, 8'h08, ALU_ADD, 1, 1, 1, 0, 1, 0);
        U31   = mk(1, 31, 3, 12, 8'h00, 8'h34, 8'h00, ALU_OR, 0, 1, 0, 0, 1, 1);
        LD6   = mk(1, 2, 0, 6, 8'h50, 8'h00, 8'h0C, ALU_ADD, 1, 1, 1, 0, 1, 0);
        N6    = mk(1, 1, 6, 10, 8'h01, 8'h66, 8'h7F, ALU_AND, 1, 1, 0, 0, 1, 0);
        INV   = mk(0, 3, 4, 5, 8'hA5, 8'h5A, 8'hFF, ALU_XOR, 1, 1, 1, 1, 1, 1);
        INV_E = mk(0, 3, 4, 5, 8'hA5, 8'h5A, 8'hFF, ALU_XOR, 0, 0, 0, 0, 1, 1);
        RT6   = mk(1, 0, 6, 0, 8'h00, 8'h99, 8'h10, ALU_ADD, 1, 0, 0, 1, 1, 1);

        //   instr  fl busy stall  expected EX  cnt frz
        add(A,     0, 0, 0, A,     0, 0);
        add(LD5,   0, 0, 0, LD5,   0, 0);
        add(U5,    0, 0, 1, BUB,   1, 0);
        add(U5,    0, 0, 0, U5,    1, 0);
        add(LD31,  0, 0, 0, LD31,  1, 0);
        add(U31,   0, 0, 0, U31,   1, 0);
        add(LD6,   0, 0, 0, LD6,   1, 0);
        add(N6,    0, 0, 0, N6,    1, 0);
        add(INV,   0, 0, 0, INV_E, 1, 0);
        add(LD5,   0, 0, 0, LD5,   1, 0);
        add(U5N,   0, 0, 0, U5N_E, 1, 0);
        add(LD5,   0, 0, 0, LD5,   1, 0);
        add(U5,    1, 0, 1, BUB,   1, 0);
        add(LD5,   0, 0, 0, LD5,   1, 0);
        add(U5,    1, 1, 1, LD5,   1, 1);
        add(U5,    1, 1, 1, LD5,   1, 1);
        add(U5,    1, 1, 1, LD5,   1, 1);
        add(U5,    1, 0, 1, BUB,   1, 0);
        add(A,     0, 0, 0, A,     1, 0);
        add(LD6,   0, 0, 0, LD6,   1, 0);
        add(RT6,   0, 0, 1, BUB,   2, 0);
        add(RT6,   0, 0, 0, RT6,   2, 0);
        add(A,     0, 1, 1, RT6,   2, 1);
        add(A,     0, 0, 0, A,     2, 0);

        rst = 1'b1;
        apply(BUB, 0, 0, 1); tick();
        apply(BUB, 0, 0, 1); tick();
        chk("reset no_x", 32'($isunknown({stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data,
            ex_rt_data, ex_imm, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
            ex_mem_write, stall_count, frozen})), 32'd0);
        chk_ex("reset", BUB);
        chk("reset stall_count", 32'(stall_count), 32'd0);
        chk("reset frozen", 32'(frozen), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            string p;
            p = $sformatf("row%0d", i);
            apply(tbl[i].ins, tbl[i].fl, tbl[i].busy, 1'b0);
            chk({p, " stall"}, 32'(stall), 32'(tbl[i].e_stall));
            tick();
            chk_ex(p, tbl[i].e_ex);
            chk({p, " stall_count"}, 32'(stall_count), 32'(tbl[i].e_cnt));
            chk({p, " frozen"}, 32'(frozen), 32'(tbl[i].e_frz));
        end

        // Reset while frozen with a valid instruction held in EX.
        apply(A, 0, 1, 0); tick();
        chk("pre_rst frozen", 32'(frozen), 32'd1);
        chk("pre_rst ex_valid", 32'(ex_valid), 32'd1);
        apply(A, 0, 1, 1); tick();
        chk("rst_frz ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_frz ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_frz frozen", 32'(frozen), 32'd0);
        chk("rst_frz stall_count", 32'(stall_count), 32'd0);

        // 20 load-use stalls against a 4-bit counter.
        for (int k = 1; k <= 20; k++) begin
            apply(LD5, 0, 0, 0); tick();
            apply(U5, 0, 0, 0);
            chk($sformatf("sat%0d stall", k), 32'(stall), 32'd1);
            tick();
            chk($sformatf("sat%0d stall_count", k), 32'(stall_count), (k > 15) ? 32'd15 : 32'(k));
            apply(U5, 0, 0, 0); tick();
            chk($sformatf("sat%0d advance", k), 32'(ex_rd), 32'd9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion, branch flush and memory-wait freeze.
- Upstream is the decode stage and register file. Downstream, EX operand muxes consume its outputs, and the forwarding unit compares ex_rs/ex_rt against MEM/WB destinations.
- Owns the pipeline stall signal sent to PC and IF/ID, and a saturating hazard-stall counter for performance debug.

Parameters:
- DATA_W, 8, operand/immediate width
- REG_W, 5, register index width
- ZERO_REG, 31, register index that is never written; excluded from hazard checks
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W  decoded register indices
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  extended immediate
- id_alu_op  in  4  ALU operation code
- id_alu_src, id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt
- ex_flush  in  1  branch taken/redirect resolved in EX
- mem_busy  in  1  data memory not ready; whole pipeline freezes
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  out  REG_W  registered indices (ex_rs/ex_rt go to the forwarding unit)
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_alu_op  out  4; ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- stall_count  out  CNT_W  saturating count of load-use bubbles
- frozen  out  1  FSM in FREEZE state

Behaviour:
- Reset (synchronous): all ex_* outputs 0, stall_count 0, state RUN. Resetting in any state returns to RUN on the next edge.
- Load-use hazard (combinational), luh = ex_valid & ex_mem_read & (ex_rd != ZERO_REG) & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- stall = luh | mem_busy. Do not gate stall with ex_flush; when flush wins, the upstream redirect overrides the hold.
- FSM has two states, RUN and FREEZE:
  - RUN→FREEZE when mem_busy=1.
  - FREEZE→RUN on the first cycle with mem_busy=0.
  - frozen=1 in FREEZE.
  - The EX register action is chosen from the current mem_busy input, not the registered state.
- Per-edge EX register action, highest priority first:
  1. rst: clear everything.
  2. mem_busy: hold all ex_* registers and stall_count unchanged. Flush and luh are ignored; upstream re-asserts ex_flush once unfrozen.
  3. ex_flush: insert bubble (ex_valid=0 and ex_reg_write/ex_mem_read/ex_mem_write=0; other fields don't-care, implemented as 0).
  4. luh: insert bubble, and stall_count += 1, saturating at all-ones.
  5. otherwise: capture all id_* fields; ex_valid=id_valid, and control bits are ANDed with id_valid.
- Latency: a non-stalled instruction appears on ex_* exactly one cycle after being presented on id_*.
- A load-use stall lasts exactly one cycle. The next cycle has ex_mem_read=0 (bubble), so luh deasserts and the instruction advances.
- No hazard when ex_rd==ZERO_REG, or when the matching operand is not used.
- No X on outputs after reset, regardless of id_* values.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_W, DATA_W, ZERO_REG
  - ALU op encodings
  - a control-bundle typedef (alu_src, reg_write, mem_read, mem_write)
  - FSM state enum {RUN, FREEZE}
- Optional sub-module load_use_detect: pure combinational luh, reusable by a future IF/ID stage. The pipeline register stays in id_ex_stage.

Test Plan:
- Reset mid-FREEZE with ex_valid=1: assert rst for 1 cycle while mem_busy=1 → next cycle ex_valid=0, frozen=0, stall_count=0.
- Normal flow: id_valid=1, rs=2, rt=3, rd=4, rs_data=8'h12, reg_write=1 → next cycle ex_rs=2, ex_rd=4, ex_rs_data=8'h12, ex_reg_write=1, stall=0.
- Load-use: EX holds load (mem_read=1, rd=5); ID rs=5, uses_rs=1 → stall=1 same cycle; next cycle ex_valid=0, stall_count=1, stall=0; following cycle the instruction appears in EX.
- ZERO_REG/unused operand: EX load rd=31, ID rs=31 → stall=0. EX load rd=6, ID rt=6 with uses_rt=0 → stall=0.
- Freeze vs flush: mem_busy=1 for 3 cycles with ex_flush=1 → ex_* unchanged, frozen=1, stall=1. mem_busy drops with ex_flush=1 → bubble captured, ex_valid=0.
- Saturation: preload with CNT_W=4 and force 20 load-use stalls → stall_count stops at 4'hF.
